// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one registered req/ack bus transfer per memory op with pipeline stall,
// endian-aware lane steering, alignment exceptions, LL/SC link tracking and a bus timeout.
module mem_lsu #(
   parameter int BIG_ENDIAN = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        flush_i,
   input  logic        ll_clear_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic        timeout_o,
   output logic        llbit_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic [1:0]  dbg_state_o
);

   localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
   localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
   localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
   localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
   localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
   localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
   localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
   localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
   localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
   localparam logic [7:0] EXE_SC_OP  = 8'b11111000;
   localparam int         CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_op;
   logic [31:2]   r_addr;
   logic [1:0]    r_off;
   logic [3:0]    r_sel;
   logic          r_we;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_llbit;
   logic [CW-1:0] r_cnt;
   logic          r_flushed;
   logic          r_timeout;

   logic          w_is_byte, w_is_half, w_is_word, w_is_load, w_is_store, w_mem_op;
   logic          w_misalign, w_idle, w_bus, w_accept, w_sc_fail, w_ack_ok, w_tmo_hit;
   logic [3:0]    w_sel;
   logic [31:0]   w_wdata;
   logic [1:0]    w_byte_lane;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load_data;

   assign w_is_byte  = (aluop_i == EXE_LB_OP) | (aluop_i == EXE_LBU_OP) | (aluop_i == EXE_SB_OP);
   assign w_is_half  = (aluop_i == EXE_LH_OP) | (aluop_i == EXE_LHU_OP) | (aluop_i == EXE_SH_OP);
   assign w_is_word  = (aluop_i == EXE_LW_OP) | (aluop_i == EXE_LL_OP) |
                       (aluop_i == EXE_SW_OP) | (aluop_i == EXE_SC_OP);
   assign w_is_load  = (aluop_i == EXE_LB_OP) | (aluop_i == EXE_LBU_OP) | (aluop_i == EXE_LH_OP) |
                       (aluop_i == EXE_LHU_OP) | (aluop_i == EXE_LW_OP) | (aluop_i == EXE_LL_OP);
   assign w_is_store = (aluop_i == EXE_SB_OP) | (aluop_i == EXE_SH_OP) |
                       (aluop_i == EXE_SW_OP) | (aluop_i == EXE_SC_OP);
   assign w_mem_op   = w_is_load | w_is_store;
   assign w_misalign = (w_is_half & addr_i[0]) | (w_is_word & (addr_i[1:0] != 2'b00));

   assign w_idle    = (r_state == S_IDLE);
   assign w_bus     = (r_state == S_BUS);
   assign w_accept  = w_idle & req_valid_i & w_mem_op & ~w_misalign & ~flush_i;
   assign w_sc_fail = (aluop_i == EXE_SC_OP) & ~r_llbit;
   // A flush seen at any point of the bus phase discards the result once the ack arrives.
   assign w_ack_ok  = bus_ack_i & ~(r_flushed | flush_i);
   assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      w_sel   = 4'b1111;
      w_wdata = wdata_i;
      if (w_is_byte) begin
         w_sel   = (BIG_ENDIAN != 0) ? (4'b1000 >> addr_i[1:0]) : (4'b0001 << addr_i[1:0]);
         w_wdata = {4{wdata_i[7:0]}};
      end else if (w_is_half) begin
         w_sel   = ((BIG_ENDIAN != 0) ^ addr_i[1]) ? 4'b1100 : 4'b0011;
         w_wdata = {2{wdata_i[15:0]}};
      end
   end

   // Lane index counts from bit 0; big-endian offset 0 lives in the top lane.
   assign w_byte_lane = (BIG_ENDIAN != 0) ? ~r_off : r_off;
   assign w_half      = ((BIG_ENDIAN != 0) ^ r_off[1]) ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

   always_comb begin
      case (w_byte_lane)
         2'd0:    w_byte = bus_rdata_i[7:0];
         2'd1:    w_byte = bus_rdata_i[15:8];
         2'd2:    w_byte = bus_rdata_i[23:16];
         default: w_byte = bus_rdata_i[31:24];
      endcase
   end

   always_comb begin
      case (r_op)
         EXE_LB_OP:  w_load_data = {{24{w_byte[7]}}, w_byte};
         EXE_LBU_OP: w_load_data = {24'd0, w_byte};
         EXE_LH_OP:  w_load_data = {{16{w_half[15]}}, w_half};
         EXE_LHU_OP: w_load_data = {16'd0, w_half};
         default:    w_load_data = bus_rdata_i;
      endcase
   end

   // Bus handshake: bus_req_o is held with stable addr/sel/we/wdata until the cycle bus_ack_i is
   // sampled high; that cycle completes the transfer and bus_rdata_i is valid only then.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = w_sc_fail ? S_RESP : S_BUS;
         end
         S_BUS: begin
            if (bus_ack_i)      w_state_nxt = w_ack_ok ? S_RESP : S_IDLE;
            else if (w_tmo_hit) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_addr    <= '0;
         r_off     <= '0;
         r_sel     <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_llbit   <= 1'b0;
         r_cnt     <= '0;
         r_flushed <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timeout <= 1'b0;
         if (w_accept) begin
            r_op      <= aluop_i;
            r_addr    <= addr_i[31:2];
            r_off     <= addr_i[1:0];
            r_sel     <= w_sel;
            r_we      <= w_is_store;
            r_wdata   <= w_wdata;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_flushed <= 1'b0;
         end
         if (w_bus) begin
            r_cnt <= r_cnt + 1'b1;
            if (flush_i) r_flushed <= 1'b1;
            if (bus_ack_i)      r_rdata   <= (r_op == EXE_SC_OP) ? 32'd1 : w_load_data;
            else if (w_tmo_hit) r_timeout <= 1'b1;
         end
         if (ll_clear_i) begin
            r_llbit <= 1'b0;
         end else if (w_bus && w_ack_ok) begin
            if (r_op == EXE_LL_OP)      r_llbit <= 1'b1;
            else if (r_op == EXE_SC_OP) r_llbit <= 1'b0;
         end
      end
   end

   assign stall_o     = (w_idle & w_accept) | w_bus;
   assign done_o      = (r_state == S_RESP);
   assign rdata_o     = r_rdata;
   assign adel_o      = w_idle & req_valid_i & w_is_load & w_misalign;
   assign ades_o      = w_idle & req_valid_i & w_is_store & w_misalign;
   assign timeout_o   = r_timeout;
   assign llbit_o     = r_llbit;
   assign bus_req_o   = w_bus;
   assign bus_we_o    = w_bus & r_we;
   assign bus_addr_o  = {r_addr, 2'b00};
   assign bus_sel_o   = r_sel;
   assign bus_wdata_o = r_wdata;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a big-endian and a little-endian instance (TIMEOUT=4) driven with directed
// vectors; expected bus beats and load results are queued at issue and checked by a monitor.
module tb_mem_lsu;

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LL  = 8'hF0;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;
   localparam logic [7:0] OP_SC  = 8'hF8;
   localparam logic [7:0] OP_NOP = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rv;
   logic [7:0]  aluop;
   logic [31:0] addr, wdata, bus_rdata;
   logic        flush, ll_clear, bus_ack;

   logic [1:0]  stall, done, adel, ades, tmo, llbit, breq, bwe;
   logic [31:0] rdata [2];
   logic [31:0] baddr [2];
   logic [31:0] bwdata [2];
   logic [3:0]  bsel [2];
   logic [1:0]  dbg [2];

   logic [32:0] rd_q [$];
   logic [68:0] bus_q [$];
   int          checks;
   int          failures;
   int          stall_cnt [2];
   int          breq_cnt [2];
   int          tmo_cnt [2];
   int          s_st, s_br, s_tm;

   always #5 clk = ~clk;

   mem_lsu #(.BIG_ENDIAN(1), .TIMEOUT(4)) u_be (
      .clk(clk), .rst(rst), .req_valid_i(rv[0]), .aluop_i(aluop), .addr_i(addr), .wdata_i(wdata),
      .flush_i(flush), .ll_clear_i(ll_clear), .stall_o(stall[0]), .done_o(done[0]),
      .rdata_o(rdata[0]), .adel_o(adel[0]), .ades_o(ades[0]), .timeout_o(tmo[0]),
      .llbit_o(llbit[0]), .bus_req_o(breq[0]), .bus_we_o(bwe[0]), .bus_addr_o(baddr[0]),
      .bus_sel_o(bsel[0]), .bus_wdata_o(bwdata[0]), .bus_ack_i(bus_ack),
      .bus_rdata_i(bus_rdata), .dbg_state_o(dbg[0])
   );

   mem_lsu #(.BIG_ENDIAN(0), .TIMEOUT(4)) u_le (
      .clk(clk), .rst(rst), .req_valid_i(rv[1]), .aluop_i(aluop), .addr_i(addr), .wdata_i(wdata),
      .flush_i(flush), .ll_clear_i(ll_clear), .stall_o(stall[1]), .done_o(done[1]),
      .rdata_o(rdata[1]), .adel_o(adel[1]), .ades_o(ades[1]), .timeout_o(tmo[1]),
      .llbit_o(llbit[1]), .bus_req_o(breq[1]), .bus_we_o(bwe[1]), .bus_addr_o(baddr[1]),
      .bus_sel_o(bsel[1]), .bus_wdata_o(bwdata[1]), .bus_ack_i(bus_ack),
      .bus_rdata_i(bus_rdata), .dbg_state_o(dbg[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic exp_bus(input logic we, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] wd);
      bus_q.push_back({we, sel, a, wd});
   endtask

   task automatic exp_rd(input logic use_it, input logic [31:0] v);
      rd_q.push_back({use_it, v});
   endtask

   task automatic check_zero(input int d, input string tag);
      chk({tag, "_ctrl"}, 32'({stall[d], done[d], adel[d], ades[d], tmo[d], llbit[d], breq[d],
                               bwe[d], dbg[d]}), 32'h0);
      chk({tag, "_rdata"}, rdata[d], 32'h0);
      chk({tag, "_bus"}, baddr[d] | bwdata[d] | 32'(bsel[d]), 32'h0);
   endtask

   task automatic monitor_loop();
      logic [32:0] r;
      logic [68:0] b;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (stall[d]) stall_cnt[d]++;
            if (breq[d])  breq_cnt[d]++;
            if (tmo[d])   tmo_cnt[d]++;
            if (done[d]) begin
               if (rd_q.size() == 0) begin
                  chk("done_unexpected", 32'(done[d]), 32'h0);
               end else begin
                  r = rd_q.pop_front();
                  if (r[32]) chk("rdata", rdata[d], r[31:0]);
               end
            end
            if (breq[d] && bus_ack) begin
               if (bus_q.size() == 0) begin
                  chk("bus_unexpected", 32'(breq[d]), 32'h0);
               end else begin
                  b = bus_q.pop_front();
                  chk("bus_we", 32'(bwe[d]), 32'(b[68]));
                  chk("bus_sel", 32'(bsel[d]), 32'(b[67:64]));
                  chk("bus_addr", baddr[d], b[63:32]);
                  if (b[68]) chk("bus_wdata", bwdata[d], b[31:0]);
               end
            end
         end
      end
   endtask

   // One request, acked after 'waits' idle bus cycles; optionally pulses ll_clear with the ack.
   task automatic txn(input int d, input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input logic clr_at_ack);
      @(posedge clk); #2;
      rv[d] = 1'b1; aluop = op; addr = a; wdata = wd;
      @(posedge clk); #2;
      rv = 2'b00; aluop = OP_NOP;
      for (int i = 0; i < waits; i++) begin
         @(posedge clk); #2;
      end
      bus_rdata = rd; bus_ack = 1'b1; ll_clear = clr_at_ack;
      @(posedge clk); #2;
      bus_ack = 1'b0; ll_clear = 1'b0; bus_rdata = 32'h0;
      @(posedge clk); #2;
   endtask

   task automatic misaligned(input int d, input logic [7:0] op, input logic [31:0] a,
                             input logic exp_adel, input logic exp_ades, input string tag);
      @(posedge clk); #2;
      rv[d] = 1'b1; aluop = op; addr = a;
      #1;
      chk({tag, "_adel"}, 32'(adel[d]), 32'(exp_adel));
      chk({tag, "_ades"}, 32'(ades[d]), 32'(exp_ades));
      chk({tag, "_stall"}, 32'(stall[d]), 32'h0);
      @(posedge clk); #2;
      rv = 2'b00; aluop = OP_NOP;
      chk({tag, "_busreq"}, 32'(breq[d]), 32'h0);
      chk({tag, "_state"}, 32'(dbg[d]), 32'h0);
   endtask

   initial begin
      checks = 0; failures = 0;
      for (int d = 0; d < 2; d++) begin
         stall_cnt[d] = 0; breq_cnt[d] = 0; tmo_cnt[d] = 0;
      end
      rst = 1'b1; rv = 2'b00; aluop = OP_NOP; addr = 32'h0; wdata = 32'h0;
      flush = 1'b0; ll_clear = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #3;
      check_zero(0, "rst_be");
      check_zero(1, "rst_le");
      rst = 1'b0;

      // LB big-endian, offset 3, three wait cycles; ack lands on the last cycle before timeout
      exp_bus(1'b0, 4'b0001, 32'h1000, 32'h0);
      exp_rd(1'b1, 32'hFFFFFFF4);
      s_st = stall_cnt[0];
      txn(0, OP_LB, 32'h1003, 32'h0, 32'h112233F4, 3, 1'b0);
      chk("lb_stall_cycles", 32'(stall_cnt[0] - s_st), 32'd5);
      chk("lb_no_timeout", 32'(tmo_cnt[0]), 32'd0);

      // LHU little-endian, offset 2, zero-wait
      exp_bus(1'b0, 4'b1100, 32'h2000, 32'h0);
      exp_rd(1'b1, 32'h00008001);
      s_st = stall_cnt[1];
      txn(1, OP_LHU, 32'h2002, 32'h0, 32'h8001ABCD, 0, 1'b0);
      chk("lhu_stall_cycles", 32'(stall_cnt[1] - s_st), 32'd2);

      misaligned(1, OP_LH, 32'h2001, 1'b1, 1'b0, "lh_mis");
      misaligned(0, OP_SW, 32'h3001, 1'b0, 1'b1, "sw_mis");
      misaligned(0, OP_LL, 32'h0042, 1'b1, 1'b0, "ll_mis");

      exp_bus(1'b1, 4'b0011, 32'h3000, 32'hBEEFBEEF);
      exp_rd(1'b0, 32'h0);
      txn(0, OP_SH, 32'h3002, 32'hDEADBEEF, 32'h0, 1, 1'b0);

      exp_bus(1'b1, 4'b0010, 32'h1000, 32'hA5A5A5A5);
      exp_rd(1'b0, 32'h0);
      txn(1, OP_SB, 32'h1001, 32'h000012A5, 32'h0, 0, 1'b0);

      exp_bus(1'b0, 4'b0010, 32'h1000, 32'h0);
      exp_rd(1'b1, 32'hFFFFFF83);
      txn(1, OP_LB, 32'h1001, 32'h0, 32'h11228344, 0, 1'b0);

      exp_bus(1'b0, 4'b0100, 32'h1004, 32'h0);
      exp_rd(1'b1, 32'h000000C2);
      txn(0, OP_LBU, 32'h1005, 32'h0, 32'h11C23344, 2, 1'b0);

      exp_bus(1'b0, 4'b1100, 32'h0010, 32'h0);
      exp_rd(1'b1, 32'hFFFF8765);
      txn(0, OP_LH, 32'h0010, 32'h0, 32'h87654321, 0, 1'b0);

      exp_bus(1'b0, 4'b1111, 32'h4000, 32'h0);
      exp_rd(1'b1, 32'h12345678);
      txn(0, OP_LW, 32'h4000, 32'h0, 32'h12345678, 1, 1'b0);

      // LL then successful SC
      exp_bus(1'b0, 4'b1111, 32'h0040, 32'h0);
      exp_rd(1'b1, 32'hCAFEF00D);
      txn(0, OP_LL, 32'h0040, 32'h0, 32'hCAFEF00D, 0, 1'b0);
      chk("ll_sets_llbit", 32'(llbit[0]), 32'd1);
      exp_bus(1'b1, 4'b1111, 32'h0040, 32'h5555AAAA);
      exp_rd(1'b1, 32'd1);
      txn(0, OP_SC, 32'h0040, 32'h5555AAAA, 32'h0, 0, 1'b0);
      chk("sc_clears_llbit", 32'(llbit[0]), 32'd0);

      // SC with llbit clear: no bus, done the next cycle with status 0
      exp_rd(1'b1, 32'd0);
      s_br = breq_cnt[0];
      @(posedge clk); #2;
      rv[0] = 1'b1; aluop = OP_SC; addr = 32'h0040; wdata = 32'h99999999;
      #1;
      chk("scfail_stall_c0", 32'(stall[0]), 32'd1);
      @(posedge clk); #2;
      rv = 2'b00; aluop = OP_NOP;
      #1;
      chk("scfail_done_c1", 32'(done[0]), 32'd1);
      chk("scfail_busreq_c1", 32'(breq[0]), 32'd0);
      @(posedge clk); #2;
      chk("scfail_no_bus", 32'(breq_cnt[0] - s_br), 32'd0);

      // ll_clear coinciding with LL completion wins
      exp_bus(1'b0, 4'b1111, 32'h0044, 32'h0);
      exp_rd(1'b1, 32'h0BADBEEF);
      txn(0, OP_LL, 32'h0044, 32'h0, 32'h0BADBEEF, 1, 1'b1);
      chk("ll_clear_wins", 32'(llbit[0]), 32'd0);

      // No ack: timeout after four request cycles
      s_st = stall_cnt[0]; s_br = breq_cnt[0]; s_tm = tmo_cnt[0];
      @(posedge clk); #2;
      rv[0] = 1'b1; aluop = OP_LW; addr = 32'h0080;
      @(posedge clk); #2;
      rv = 2'b00; aluop = OP_NOP;
      repeat (8) @(posedge clk);
      #2;
      chk("tmo_busreq_cycles", 32'(breq_cnt[0] - s_br), 32'd4);
      chk("tmo_pulses", 32'(tmo_cnt[0] - s_tm), 32'd1);
      chk("tmo_stall_cycles", 32'(stall_cnt[0] - s_st), 32'd5);
      chk("tmo_idle", 32'(dbg[0]), 32'd0);

      // Flush during BUS: beat still completes, result discarded
      exp_bus(1'b0, 4'b1111, 32'h0090, 32'h0);
      @(posedge clk); #2;
      rv[0] = 1'b1; aluop = OP_LW; addr = 32'h0090;
      @(posedge clk); #2;
      rv = 2'b00; aluop = OP_NOP; flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
      chk("flush_still_busreq", 32'(breq[0]), 32'd1);
      @(posedge clk); #2;
      bus_ack = 1'b1; bus_rdata = 32'h77777777;
      @(posedge clk); #2;
      bus_ack = 1'b0; bus_rdata = 32'h0;
      chk("flush_back_idle", 32'(dbg[0]), 32'd0);
      chk("flush_no_stall", 32'(stall[0]), 32'd0);
      repeat (2) @(posedge clk);
      #2;

      // Reset in the middle of a bus wait
      @(posedge clk); #2;
      rv[0] = 1'b1; aluop = OP_LW; addr = 32'h00A0; wdata = 32'h0;
      @(posedge clk); #2;
      rv = 2'b00; aluop = OP_NOP;
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      check_zero(0, "rst_bus");
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;

      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
      chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
